audio_fade_ctrl: RTL and testbench

AUDIO_FADE_CTRL -- requirements
Module: audio_fade_ctrl

---
 rtl/audio_fade_ctrl_if.sv | 22 ++
 rtl/audio_fade_ctrl.sv | 141 ++++++++++++++
 tb/tb_audio_fade_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/audio_fade_ctrl_if.sv
// Control/audio bus of the fade controller: config write, mute level, sample path and status.
interface audio_fade_ctrl_if;
  logic       cfg_we;
  logic [7:0] cfg_data;
  logic       cfg_ack;
  logic       mute_req;
  logic [7:0] sample_in;
  logic [7:0] sample_out;
  logic       busy;

  // Host / mixer side
  modport master (
    output cfg_we, cfg_data, mute_req, sample_in,
    input  cfg_ack, sample_out, busy
  );

  // Fade controller side
  modport slave (
    input  cfg_we, cfg_data, mute_req, sample_in,
    output cfg_ack, sample_out, busy
  );
endinterface

// File: rtl/audio_fade_ctrl.sv
// Audio fade controller: ramps an 8-bit gain toward a target volume (or to zero on mute)
// at a prescaled tick rate and applies the gain to an excess-128 sample stream.
module audio_fade_ctrl #(
  parameter int unsigned PRESCALE  = 255,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic              clkdac,
  input  logic              reset,
  audio_fade_ctrl_if.slave  bus
);

  localparam int unsigned PW = 16;
  localparam int unsigned GW = 8;
  localparam int unsigned MW = 17;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t               r_state;
  logic [GW-1:0]        r_gain;
  logic [GW-1:0]        r_target;
  logic                 r_ack;
  logic                 r_busy;
  logic [PW-1:0]        r_presc;
  logic signed [MW-1:0] r_p;
  logic [GW-1:0]        r_out;

  logic                 w_tick;
  logic [GW-1:0]        w_eff;
  logic [GW:0]          w_up_sum;
  logic [GW-1:0]        w_up_next;
  logic [GW-1:0]        w_dn_next;
  logic signed [MW-1:0] w_smp;
  logic signed [MW-1:0] w_gain_s;

  // Effective target and clamped next gain values in both directions
  always_comb begin
    w_tick    = (r_presc == PW'(PRESCALE));
    w_eff     = bus.mute_req ? '0 : r_target;
    w_up_sum  = {1'b0, r_gain} + (GW+1)'(RAMP_STEP);
    w_up_next = (w_up_sum > {1'b0, w_eff}) ? w_eff : w_up_sum[GW-1:0];
    w_dn_next = ({1'b0, r_gain} < ({1'b0, w_eff} + (GW+1)'(RAMP_STEP)))
                ? w_eff : (r_gain - GW'(RAMP_STEP));
    // sample_in - 128 sign-extended: flipping the MSB converts excess-128 to two's complement
    w_smp     = {{(MW-7){~bus.sample_in[7]}}, bus.sample_in[6:0]};
    w_gain_s  = {{(MW-GW){1'b0}}, r_gain};
  end

  // Target register and one-cycle write acknowledge
  always_ff @(posedge clkdac) begin
    if (reset) begin
      r_target <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= bus.cfg_we;
      if (bus.cfg_we) r_target <= bus.cfg_data;
    end
  end

  // Free-running ramp prescaler; tick is the cycle the count sits at PRESCALE
  always_ff @(posedge clkdac) begin
    if (reset)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Fade FSM: gain only moves on ticks while ramping; busy tracks the ramp states
  always_ff @(posedge clkdac) begin
    if (reset) begin
      r_state <= MUTED;
      r_gain  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        MUTED: begin
          r_gain <= '0;
          if (w_eff != '0) begin
            r_state <= RAMP_UP;
            r_busy  <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (w_eff < r_gain) begin
            r_state <= RAMP_DOWN;
            r_busy  <= 1'b1;
          end else if (w_eff == r_gain) begin
            r_state <= PLAY;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            r_gain <= w_up_next;
          end
        end
        RAMP_DOWN: begin
          if (w_eff > r_gain) begin
            r_state <= RAMP_UP;
            r_busy  <= 1'b1;
          end else if (w_eff == r_gain) begin
            r_state <= (w_eff == '0) ? MUTED : PLAY;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            r_gain <= w_dn_next;
          end
        end
        PLAY: begin
          if (w_eff > r_gain) begin
            r_state <= RAMP_UP;
            r_busy  <= 1'b1;
          end else if (w_eff < r_gain) begin
            r_state <= RAMP_DOWN;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= MUTED;
          r_gain  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage gain multiply: signed product, then floor shift back to excess-128
  always_ff @(posedge clkdac) begin
    if (reset) begin
      r_p   <= '0;
      r_out <= 8'h80;
    end else begin
      r_p   <= w_smp * w_gain_s;
      r_out <= GW'((r_p >>> 8) + MW'(128));
    end
  end

  assign bus.cfg_ack    = r_ack;
  assign bus.busy       = r_busy;
  assign bus.sample_out = r_out;

endmodule

// File: tb/tb_audio_fade_ctrl.sv
// Scoreboard bench for audio_fade_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_audio_fade_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_fade_ctrl_if bus_a ();
  audio_fade_ctrl_if bus_b ();

  audio_fade_ctrl #(.PRESCALE(3), .RAMP_STEP(16)) dut_a (
    .clkdac (clk),
    .reset  (rst),
    .bus    (bus_a)
  );

  audio_fade_ctrl #(.PRESCALE(3), .RAMP_STEP(200)) dut_b (
    .clkdac (clk),
    .reset  (rst),
    .bus    (bus_b)
  );

  typedef struct {
    int         cyc;
    int         dut;
    int         kind;   // 0 = sample_out, 1 = busy
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   ack_qa[$];
  int   ack_qb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_act(int d, int kind);
    if (d == 0) return (kind == 0) ? int'(bus_a.sample_out) : int'(bus_a.busy);
    else        return (kind == 0) ? int'(bus_b.sample_out) : int'(bus_b.busy);
  endfunction

  task automatic chk(string nm, int act, int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, act, want);
  endtask

  // Monitor: compare every expectation due this cycle, and every cfg_ack pulse
  always @(negedge clk) begin
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) chk(sb[i].name, get_act(sb[i].dut, sb[i].kind), int'(sb[i].val));
      else keep.push_back(sb[i]);
    end
    sb = keep;
    if (ack_qa.size() > 0 && ack_qa[0] == cyc) begin
      void'(ack_qa.pop_front());
      chk("ack_a", int'(bus_a.cfg_ack), 1);
    end else if (bus_a.cfg_ack) begin
      chk("ack_a_spurious", int'(bus_a.cfg_ack), 0);
    end
    if (ack_qb.size() > 0 && ack_qb[0] == cyc) begin
      void'(ack_qb.pop_front());
      chk("ack_b", int'(bus_b.cfg_ack), 1);
    end else if (bus_b.cfg_ack) begin
      chk("ack_b_spurious", int'(bus_b.cfg_ack), 0);
    end
  end

  task automatic ex(int d, int at, int kind, logic [7:0] v, string nm);
    exp_t e;
    e.cyc = at; e.dut = d; e.kind = kind; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic go(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic idle();
    bus_a.cfg_we = 1'b0; bus_a.cfg_data = 8'h00; bus_a.mute_req = 1'b0; bus_a.sample_in = 8'h00;
    bus_b.cfg_we = 1'b0; bus_b.cfg_data = 8'h00; bus_b.mute_req = 1'b0; bus_b.sample_in = 8'h00;
  endtask

  // Two reset cycles; returns the cycle index of the negedge where reset drops
  task automatic do_reset(output int r);
    @(negedge clk);
    rst = 1'b1;
    idle();
    ex(0, cyc + 1, 0, 8'h80, "rst_out_a");
    ex(0, cyc + 1, 1, 8'h00, "rst_busy_a");
    ex(1, cyc + 1, 0, 8'h80, "rst_out_b");
    ex(1, cyc + 1, 1, 8'h00, "rst_busy_b");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
  endtask

  int r;

  initial begin
    idle();

    // Ramp up to 0x40 in four ticks, then PLAY and scale a few samples
    do_reset(r);
    bus_a.cfg_we = 1'b1; bus_a.cfg_data = 8'h40; ack_qa.push_back(r + 1);
    ex(0, r + 2,  1, 8'h01, "t1_busy_start");
    ex(0, r + 5,  0, 8'h80, "t1_g0");
    ex(0, r + 6,  0, 8'h78, "t1_g16");
    ex(0, r + 10, 0, 8'h70, "t1_g32");
    ex(0, r + 14, 0, 8'h68, "t1_g48");
    ex(0, r + 16, 1, 8'h01, "t1_busy_last");
    ex(0, r + 17, 1, 8'h00, "t1_busy_play");
    ex(0, r + 18, 0, 8'h60, "t1_g64");
    go(r + 1);  bus_a.cfg_we = 1'b0;
    go(r + 20); bus_a.sample_in = 8'hFF; ex(0, r + 22, 0, 8'h9F, "t1_ff");
    go(r + 21); bus_a.sample_in = 8'h00; ex(0, r + 23, 0, 8'h60, "t1_00");
    go(r + 22); bus_a.sample_in = 8'h80; ex(0, r + 24, 0, 8'h80, "t1_80");
    go(r + 23); bus_a.sample_in = 8'hC0; ex(0, r + 25, 0, 8'h90, "t1_c0");
    go(r + 24); bus_a.sample_in = 8'h00;
    go(r + 30);

    // Mute at gain 48 mid ramp-up, fade to MUTED, release and ramp back
    do_reset(r);
    bus_a.cfg_we = 1'b1; bus_a.cfg_data = 8'h40; ack_qa.push_back(r + 1);
    go(r + 1);  bus_a.cfg_we = 1'b0;
    go(r + 12); bus_a.mute_req = 1'b1;
    ex(0, r + 13, 1, 8'h01, "t2_busy_down");
    ex(0, r + 14, 0, 8'h68, "t2_g48");
    ex(0, r + 17, 0, 8'h68, "t2_g48_hold");
    ex(0, r + 18, 0, 8'h70, "t2_g32");
    ex(0, r + 22, 0, 8'h78, "t2_g16");
    ex(0, r + 24, 1, 8'h01, "t2_busy_g0");
    ex(0, r + 25, 1, 8'h00, "t2_busy_muted");
    ex(0, r + 26, 0, 8'h80, "t2_silent");
    go(r + 28); bus_a.mute_req = 1'b0;
    ex(0, r + 29, 1, 8'h01, "t2_busy_up");
    ex(0, r + 33, 0, 8'h80, "t2_up_g0");
    ex(0, r + 34, 0, 8'h78, "t2_up_g16");
    ex(0, r + 44, 1, 8'h01, "t2_busy_up_last");
    ex(0, r + 45, 1, 8'h00, "t2_busy_play");
    ex(0, r + 46, 0, 8'h60, "t2_up_g64");
    go(r + 50);

    // New target written on a tick edge: that step still uses the old target
    do_reset(r);
    bus_a.cfg_we = 1'b1; bus_a.cfg_data = 8'h40; ack_qa.push_back(r + 1);
    go(r + 1);  bus_a.cfg_we = 1'b0;
    go(r + 11); bus_a.cfg_we = 1'b1; bus_a.cfg_data = 8'h20; ack_qa.push_back(r + 12);
    go(r + 12); bus_a.cfg_we = 1'b0;
    ex(0, r + 13, 1, 8'h01, "t3_busy_rev");
    ex(0, r + 14, 0, 8'h68, "t3_old_target_step");
    ex(0, r + 16, 1, 8'h01, "t3_busy_down");
    ex(0, r + 17, 1, 8'h00, "t3_busy_play");
    ex(0, r + 18, 0, 8'h70, "t3_g32");
    ex(0, r + 20, 0, 8'h70, "t3_g32_hold");
    go(r + 24);

    // Reset mid-ramp with a simultaneous write: write ignored, no ack
    do_reset(r);
    bus_a.cfg_we = 1'b1; bus_a.cfg_data = 8'h40; ack_qa.push_back(r + 1);
    go(r + 1);  bus_a.cfg_we = 1'b0;
    go(r + 9);  rst = 1'b1; bus_a.cfg_we = 1'b1; bus_a.cfg_data = 8'h77;
    ex(0, r + 10, 0, 8'h80, "t4_rst_out");
    ex(0, r + 10, 1, 8'h00, "t4_rst_busy");
    go(r + 10); rst = 1'b0; bus_a.cfg_we = 1'b0; bus_a.sample_in = 8'hFF;
    ex(0, r + 12, 1, 8'h00, "t4_stay_idle");
    ex(0, r + 12, 0, 8'h80, "t4_out_g0");
    ex(0, r + 14, 0, 8'h80, "t4_out_g0_late");
    go(r + 16); bus_a.sample_in = 8'h00;

    // Large step: clamp at 255 going up and at the target going down
    do_reset(r);
    bus_b.cfg_we = 1'b1; bus_b.cfg_data = 8'hFF; ack_qb.push_back(r + 1);
    go(r + 1);  bus_b.cfg_we = 1'b0;
    ex(1, r + 2,  1, 8'h01, "t5_busy_up");
    ex(1, r + 6,  0, 8'h1C, "t5_g200");
    ex(1, r + 8,  1, 8'h01, "t5_busy_g255");
    ex(1, r + 9,  1, 8'h00, "t5_busy_play");
    ex(1, r + 10, 0, 8'h00, "t5_g255_00");
    go(r + 10); bus_b.sample_in = 8'hFF; ex(1, r + 12, 0, 8'hFE, "t5_g255_ff");
    go(r + 11); bus_b.sample_in = 8'h00; ex(1, r + 13, 0, 8'h00, "t5_g255_00b");
    go(r + 12); bus_b.cfg_we = 1'b1; bus_b.cfg_data = 8'h10; ack_qb.push_back(r + 13);
    go(r + 13); bus_b.cfg_we = 1'b0;
    ex(1, r + 14, 1, 8'h01, "t5_busy_down");
    ex(1, r + 17, 0, 8'h00, "t5_g255_hold");
    ex(1, r + 18, 0, 8'h64, "t5_g55");
    ex(1, r + 20, 1, 8'h01, "t5_busy_g16");
    ex(1, r + 21, 1, 8'h00, "t5_busy_play2");
    ex(1, r + 22, 0, 8'h78, "t5_g16");
    go(r + 26);

    foreach (sb[i]) begin
      n_chk++;
      $display("FAIL %s never compared: due cyc=%0d want=0x%0h", sb[i].name, sb[i].cyc, sb[i].val);
    end
    foreach (ack_qa[i]) begin
      n_chk++;
      $display("FAIL ack_a missing at cyc=%0d got=none want=1", ack_qa[i]);
    end
    foreach (ack_qb[i]) begin
      n_chk++;
      $display("FAIL ack_b missing at cyc=%0d got=none want=1", ack_qb[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
